// File: rtl/pixel_pack_16i_256o.sv
// Write-side width packer: gathers IN_WIDTH pixel beats into OUT_WIDTH words
// and writes them into a wr_en/wr_full FIFO, with one pending word plus one accumulator.
module pixel_pack_16i_256o #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 256,
  parameter int CNT_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_wr_en,
  output logic [OUT_WIDTH-1:0] out_wr_data,
  output logic                 out_last,
  input  logic                 out_wr_full,
  output logic [CNT_WIDTH-1:0] word_count
);

  localparam int RATIO  = OUT_WIDTH / IN_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic {FILL, HELD} state_e;

  state_e                 state_q, state_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [OUT_WIDTH-1:0]   acc_q, acc_d;
  logic                   acc_last_q, acc_last_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [OUT_WIDTH-1:0]   pend_data_q, pend_data_d;
  logic                   pend_last_q, pend_last_d;
  logic [CNT_WIDTH-1:0]   word_count_q, word_count_d;

  logic                   accept, drain, complete;
  logic [OUT_WIDTH-1:0]   word;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    lane_d       = lane_q;
    acc_d        = acc_q;
    acc_last_d   = acc_last_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_last_d  = pend_last_q;
    word_count_d = word_count_q;

    accept   = in_valid && (state_q == FILL);
    drain    = pend_valid_q && !out_wr_full;
    word     = acc_q;
    word[IN_WIDTH*lane_q +: IN_WIDTH] = in_data;
    complete = accept && ((lane_q == LANE_W'(RATIO - 1)) || in_last);

    if (drain) begin
      pend_valid_d = 1'b0;
      word_count_d = word_count_q + 1'b1;
    end

    case (state_q)
      FILL: begin
        if (complete) begin
          lane_d = '0;
          // Lanes never written stay zero because the accumulator is cleared per word.
          if (!pend_valid_q || drain) begin
            pend_valid_d = 1'b1;
            pend_data_d  = word;
            pend_last_d  = in_last;
            acc_d        = '0;
          end else begin
            acc_d      = word;
            acc_last_d = in_last;
            state_d    = HELD;
          end
        end else if (accept) begin
          acc_d  = word;
          lane_d = lane_q + 1'b1;
        end
      end
      HELD: begin
        if (drain) begin
          pend_valid_d = 1'b1;
          pend_data_d  = acc_q;
          pend_last_d  = acc_last_q;
          acc_d        = '0;
          acc_last_d   = 1'b0;
          state_d      = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      lane_q       <= '0;
      acc_q        <= '0;
      acc_last_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_last_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      acc_q        <= acc_d;
      acc_last_q   <= acc_last_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_last_q  <= pend_last_d;
      word_count_q <= word_count_d;
    end
  end

  assign in_ready    = (state_q == FILL);
  assign out_wr_en   = drain;
  assign out_wr_data = pend_data_q;
  assign out_last    = pend_last_q;
  assign word_count  = word_count_q;

endmodule

// File: tb/tb_pixel_pack_16i_256o.sv
// Bench for pixel_pack_16i_256o: per-cycle vector table, directed corner sequences,
// and random traffic checked against a queue-of-words reference model.
module tb_pixel_pack_16i_256o;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [15:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic         out_wr_en;
  logic [255:0] out_wr_data;
  logic         out_last;
  logic         out_wr_full = 1'b0;
  logic [19:0]  word_count;

  pixel_pack_16i_256o dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_wr_en(out_wr_en), .out_wr_data(out_wr_data),
    .out_last(out_last), .out_wr_full(out_wr_full), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of completed-but-unwritten words, built from the accepted beat stream.
  typedef struct { logic [255:0] word; logic last; } word_t;
  word_t        exp_q[$];
  logic [255:0] m_acc;
  int           m_lane;
  int           m_count;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_acc   = '0;
      m_lane  = 0;
      m_count = 0;
    end else begin
      automatic bit exp_ready = (exp_q.size() < 2);
      automatic bit exp_wr    = (exp_q.size() > 0) && !out_wr_full;
      check("in_ready", in_ready, exp_ready);
      check("wr_en", out_wr_en, exp_wr);
      check("word_count", word_count, 20'(m_count));
      if (exp_q.size() > 0) begin
        check("wr_data", out_wr_data, exp_q[0].word);
        check("out_last", out_last, exp_q[0].last);
      end
      if (exp_wr) begin
        void'(exp_q.pop_front());
        m_count++;
      end
      if (in_valid && exp_ready) begin
        m_acc[m_lane*16 +: 16] = in_data;
        m_lane++;
        if (m_lane == 16 || in_last) begin
          exp_q.push_back('{m_acc, in_last});
          m_acc  = '0;
          m_lane = 0;
        end
      end
    end
  end

  task automatic do_reset();
    in_valid = 1'b0; in_last = 1'b0; out_wr_full = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    bit ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    if (!ok) check("send_timeout", 1'b0, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic flush();
    int i;
    for (i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("flush_empty", 256'(exp_q.size()), 256'd0);
  endtask

  typedef struct {
    logic v; logic [15:0] d; logic l; logic f;
    logic e_ready; logic e_wren; logic chk_last; logic e_last; logic [19:0] e_count;
  } vec_t;

  vec_t vecs[8];
  int   accepted;
  bit   r, tog_done;

  initial begin
    // Five beats closed early by in_last, then a full stall, then the write.
    vecs[0] = '{1, 16'hA001, 0, 0, 1, 0, 0, 0, 20'd0};
    vecs[1] = '{1, 16'hA002, 0, 0, 1, 0, 0, 0, 20'd0};
    vecs[2] = '{1, 16'hA003, 0, 0, 1, 0, 0, 0, 20'd0};
    vecs[3] = '{1, 16'hA004, 0, 0, 1, 0, 0, 0, 20'd0};
    vecs[4] = '{1, 16'hA005, 1, 0, 1, 0, 0, 0, 20'd0};
    vecs[5] = '{0, 16'h0000, 0, 1, 1, 0, 1, 1, 20'd0};
    vecs[6] = '{0, 16'h0000, 0, 0, 1, 1, 1, 1, 20'd0};
    vecs[7] = '{0, 16'h0000, 0, 0, 1, 0, 0, 0, 20'd1};

    do_reset();
    check("rst_ready", in_ready, 1'b1);
    check("rst_wren", out_wr_en, 1'b0);
    check("rst_data", out_wr_data, 256'd0);
    check("rst_last", out_last, 1'b0);
    check("rst_count", word_count, 20'd0);

    for (int i = 0; i < 8; i++) begin
      in_valid = vecs[i].v; in_data = vecs[i].d; in_last = vecs[i].l; out_wr_full = vecs[i].f;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", i), in_ready, vecs[i].e_ready);
      check($sformatf("tbl%0d_wren", i), out_wr_en, vecs[i].e_wren);
      check($sformatf("tbl%0d_count", i), word_count, vecs[i].e_count);
      if (vecs[i].chk_last) check($sformatf("tbl%0d_last", i), out_last, vecs[i].e_last);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; out_wr_full = 1'b0;

    // 32 back-to-back beats.
    do_reset();
    for (int i = 0; i < 32; i++) send(16'(i), 1'b0);
    flush();
    check("t1_count", word_count, 20'd2);

    // FIFO full while 40 beats are offered: only 32 fit.
    do_reset();
    out_wr_full = 1'b1;
    accepted = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 60 && accepted < 40; c++) begin
      in_data = 16'h3000 + 16'(accepted);
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) accepted++;
    end
    in_valid = 1'b0;
    check("t3_accepts", 256'(accepted), 256'd32);
    out_wr_full = 1'b0;
    for (int i = 32; i < 48; i++) send(16'h3000 + 16'(i), 1'b0);
    flush();
    check("t3_count", word_count, 20'd3);

    // 256 beats while full toggles every cycle.
    do_reset();
    tog_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 256; i++) send(16'h4000 + 16'(i), 1'b0);
        tog_done = 1'b1;
      end
      begin
        while (!tog_done) begin
          @(posedge clk); #1;
          if (!tog_done) out_wr_full = ~out_wr_full;
        end
      end
    join
    out_wr_full = 1'b0;
    flush();
    check("t4_count", word_count, 20'd16);

    // Reset mid-word with a word still pending behind a full FIFO.
    do_reset();
    out_wr_full = 1'b1;
    for (int i = 0; i < 23; i++) send(16'h5000 + 16'(i), 1'b0);
    rst = 1'b1;
    #1;
    check("t5_ready", in_ready, 1'b1);
    check("t5_wren", out_wr_en, 1'b0);
    check("t5_data", out_wr_data, 256'd0);
    check("t5_last", out_last, 1'b0);
    check("t5_count", word_count, 20'd0);
    out_wr_full = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) send(16'h6000 + 16'(i), 1'b0);
    flush();
    check("t5_count_after", word_count, 20'd1);

    // in_last on the 16th beat, then a lone beat starting a new word.
    do_reset();
    for (int i = 0; i < 16; i++) send(16'h7000 + 16'(i), i == 15);
    send(16'h7777, 1'b1);
    flush();
    check("t6_count", word_count, 20'd2);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_data     = 16'($urandom);
      in_last     = ($urandom_range(0, 7) == 0);
      out_wr_full = ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; out_wr_full = 1'b0;
    flush();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
